// File: rtl/lfsr_pkg.sv
// ============================================================================
// Module      : lfsr_pkg
// Description : Shared types, constants and the LFSR step function for the
//               range-draw random source.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lfsr_pkg;

    // Draw FSM encoding
    typedef logic [1:0] draw_state_t;
    localparam draw_state_t c_IDLE = 2'd0;
    localparam draw_state_t c_DRAW = 2'd1;
    localparam draw_state_t c_HOLD = 2'd2;

    // Widest LFSR the step function supports
    localparam int unsigned c_LFSR_MAX_W = 64;

    // Feedback masks for a 32-bit register
    localparam logic [31:0] c_TAPS_32_DEFAULT = 32'h8000_0002;
    localparam logic [31:0] c_TAPS_32_MAXLEN  = 32'h8020_0003;

    // Default nonzero seed
    localparam logic [31:0] c_SEED_32_DEFAULT = 32'h00FF_FFFF;

    // One Fibonacci step: shift left, feedback = parity of tapped bits.
    // Callers zero-extend narrower states and truncate the result; the
    // zero upper bits never contribute to the parity.
    function automatic logic [c_LFSR_MAX_W-1:0] lfsr_step(
        input logic [c_LFSR_MAX_W-1:0] state,
        input logic [c_LFSR_MAX_W-1:0] taps
    );
        return {state[c_LFSR_MAX_W-2:0], ^(state & taps)};
    endfunction

endpackage

`default_nettype wire

// File: rtl/lfsr_core.sv
// ============================================================================
// Module      : lfsr_core
// Description : Free-running LFSR state register with seed reload and
//               recovery from the all-zero lockup state.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lfsr_core
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH = 32,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(c_TAPS_32_DEFAULT),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(c_SEED_32_DEFAULT)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_enable,
    input  logic             i_seed_load,
    input  logic [WIDTH-1:0] i_seed_in,
    output logic [WIDTH-1:0] o_state
);

    logic [WIDTH-1:0] r_state;

    // Seed load beats zero recovery, which beats the normal advance
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= SEED;
        end else if (i_seed_load) begin
            r_state <= (i_seed_in != '0) ? i_seed_in : SEED;
        end else if (r_state == '0) begin
            r_state <= SEED;
        end else if (i_enable) begin
            r_state <= WIDTH'(lfsr_step(c_LFSR_MAX_W'(r_state), c_LFSR_MAX_W'(TAPS)));
        end
    end

    assign o_state = r_state;

endmodule

`default_nettype wire

// File: rtl/lfsr_range_draw.sv
// ============================================================================
// Module      : lfsr_range_draw
// Description : Turns an LFSR into handshaked draws in [0, RANGE) using
//               bounded rejection sampling with a deterministic fallback and
//               an optional no-immediate-repeat rule.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lfsr_range_draw
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] TAPS      = WIDTH'(c_TAPS_32_DEFAULT),
    parameter logic [WIDTH-1:0] SEED      = WIDTH'(c_SEED_32_DEFAULT),
    parameter int unsigned      RANGE     = 9,
    parameter int unsigned      OUT_W     = 4,
    parameter int unsigned      MAX_TRIES = 8,
    parameter bit               NO_REPEAT = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             req,
    input  logic             ack,
    output logic             valid,
    output logic [OUT_W-1:0] value,
    output logic             busy,
    output logic [WIDTH-1:0] state_out
);

    localparam int unsigned       c_TRIES_W      = $clog2(MAX_TRIES + 1);
    localparam int unsigned       c_TRIES_LAST_I = MAX_TRIES - 1;
    localparam logic [c_TRIES_W-1:0] c_TRIES_LAST = c_TRIES_LAST_I[c_TRIES_W-1:0];
    localparam logic [c_TRIES_W-1:0] c_TRIES_MAX  = MAX_TRIES[c_TRIES_W-1:0];
    // One extra bit so RANGE == 2**OUT_W is representable
    localparam logic [OUT_W:0]    c_RANGE        = RANGE[OUT_W:0];

    logic [WIDTH-1:0]     w_state;
    logic [OUT_W-1:0]     w_cand;
    logic [OUT_W:0]       w_last_inc;
    logic [OUT_W-1:0]     w_fallback;
    logic                 w_accept;

    draw_state_t          r_fsm;
    logic                 r_valid;
    logic                 r_busy;
    logic [OUT_W-1:0]     r_value;
    logic [OUT_W-1:0]     r_last;
    logic [c_TRIES_W-1:0] r_tries;

    lfsr_core #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .SEED  (SEED)
    ) u_core (
        .clock       (clock),
        .reset       (reset),
        .i_enable    (enable),
        .i_seed_load (seed_load),
        .i_seed_in   (seed_in),
        .o_state     (w_state)
    );

    // Candidate qualification and the wrap-around fallback, which always
    // differs from the previous draw and therefore also honours NO_REPEAT
    always_comb begin
        w_cand     = w_state[OUT_W-1:0];
        w_last_inc = {1'b0, r_last} + {{OUT_W{1'b0}}, 1'b1};
        w_fallback = (w_last_inc == c_RANGE) ? '0 : w_last_inc[OUT_W-1:0];
        w_accept   = ({1'b0, w_cand} < c_RANGE) && (!NO_REPEAT || (w_cand != r_last));
    end

    // Draw FSM: IDLE waits for req, DRAW samples on enabled cycles, HOLD
    // presents the value until ack
    always_ff @(posedge clock) begin
        if (reset) begin
            r_fsm   <= c_IDLE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_value <= '0;
            r_last  <= '0;
            r_tries <= '0;
        end else begin
            case (r_fsm)
                c_IDLE: begin
                    if (req) begin
                        r_fsm   <= c_DRAW;
                        r_busy  <= 1'b1;
                        r_tries <= '0;
                    end
                end
                c_DRAW: begin
                    if (enable) begin
                        if (w_accept) begin
                            r_value <= w_cand;
                            r_last  <= w_cand;
                            r_valid <= 1'b1;
                            r_fsm   <= c_HOLD;
                        end else if (r_tries >= c_TRIES_LAST) begin
                            r_value <= w_fallback;
                            r_last  <= w_fallback;
                            r_valid <= 1'b1;
                            r_fsm   <= c_HOLD;
                            r_tries <= c_TRIES_MAX;
                        end else begin
                            r_tries <= r_tries + c_TRIES_W'(1);
                        end
                    end
                end
                c_HOLD: begin
                    if (ack) begin
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_fsm   <= c_IDLE;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_fsm   <= c_IDLE;
                end
            endcase
        end
    end

    assign valid     = r_valid;
    assign value     = r_value;
    assign busy      = r_busy;
    assign state_out = w_state;

endmodule

`default_nettype wire

// File: tb/tb_lfsr_range_draw.sv
// ============================================================================
// Module      : tb_lfsr_range_draw
// Description : Directed self-checking bench for lfsr_range_draw.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lfsr_range_draw;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int n_vec = 0;
    int n_bad = 0;

    // Default-parameter instance, driven from the vector table
    logic        reset, enable, seed_load, req, ack;
    logic [31:0] seed_in;
    logic        valid, busy;
    logic [3:0]  value;
    logic [31:0] state_out;

    lfsr_range_draw u_dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .seed_load (seed_load),
        .seed_in   (seed_in),
        .req       (req),
        .ack       (ack),
        .valid     (valid),
        .value     (value),
        .busy      (busy),
        .state_out (state_out)
    );

    // NO_REPEAT instance
    logic        nr_reset, nr_enable, nr_seed_load, nr_req, nr_ack;
    logic [31:0] nr_seed_in;
    logic        nr_valid, nr_busy;
    logic [3:0]  nr_value;
    logic [31:0] nr_state_out;

    lfsr_range_draw #(.NO_REPEAT(1'b1)) u_nr (
        .clock     (clock),
        .reset     (nr_reset),
        .enable    (nr_enable),
        .seed_load (nr_seed_load),
        .seed_in   (nr_seed_in),
        .req       (nr_req),
        .ack       (nr_ack),
        .valid     (nr_valid),
        .value     (nr_value),
        .busy      (nr_busy),
        .state_out (nr_state_out)
    );

    // Instance whose taps let the register fall into the zero state
    logic        z_reset, z_enable, z_seed_load, z_req, z_ack;
    logic [31:0] z_seed_in;
    logic        z_valid, z_busy;
    logic [3:0]  z_value;
    logic [31:0] z_state_out;

    lfsr_range_draw #(.TAPS(32'h0000_0001)) u_zr (
        .clock     (clock),
        .reset     (z_reset),
        .enable    (z_enable),
        .seed_load (z_seed_load),
        .seed_in   (z_seed_in),
        .req       (z_req),
        .ack       (z_ack),
        .valid     (z_valid),
        .value     (z_value),
        .busy      (z_busy),
        .state_out (z_state_out)
    );

    typedef struct {
        logic        rst, en, sl;
        logic [31:0] sin;
        logic        rq, ak;
        logic        e_valid;
        logic [3:0]  e_value;
        logic        e_busy;
        logic [31:0] e_state;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic en, input logic sl, input logic [31:0] sin,
                       input logic rq, input logic ak, input logic ev, input logic [3:0] evl,
                       input logic eb, input logic [31:0] es);
        vec_t v;
        v.rst = rst; v.en = en; v.sl = sl; v.sin = sin; v.rq = rq; v.ak = ak;
        v.e_valid = ev; v.e_value = evl; v.e_busy = eb; v.e_state = es;
        vecs.push_back(v);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        int lat;
        reset = 1'b1; enable = 1'b1; seed_load = 1'b0; seed_in = '0; req = 1'b0; ack = 1'b0;
        nr_reset = 1'b1; nr_enable = 1'b1; nr_seed_load = 1'b0; nr_seed_in = '0; nr_req = 1'b0; nr_ack = 1'b0;
        z_reset = 1'b1; z_enable = 1'b1; z_seed_load = 1'b0; z_seed_in = '0; z_req = 1'b0; z_ack = 1'b0;

        //   rst en sl sin           rq ak | valid value busy state
        // reset, free-run, enable low holds
        add(1, 1, 0, 32'h0,        0, 0,   0, 0, 0, 32'h00FF_FFFF);
        add(0, 1, 0, 32'h0,        0, 0,   0, 0, 0, 32'h01FF_FFFF);
        add(0, 1, 0, 32'h0,        0, 0,   0, 0, 0, 32'h03FF_FFFF);
        add(0, 0, 0, 32'h0,        0, 0,   0, 0, 0, 32'h03FF_FFFF);
        // req right after reset: nibble F rejected 8 times, fallback 1
        add(1, 1, 0, 32'h0,        0, 0,   0, 0, 0, 32'h00FF_FFFF);
        add(0, 1, 0, 32'h0,        1, 0,   0, 0, 1, 32'h01FF_FFFF);
        add(0, 1, 0, 32'h0,        0, 0,   0, 0, 1, 32'h03FF_FFFF);
        add(0, 1, 0, 32'h0,        0, 0,   0, 0, 1, 32'h07FF_FFFF);
        add(0, 1, 0, 32'h0,        0, 0,   0, 0, 1, 32'h0FFF_FFFF);
        add(0, 1, 0, 32'h0,        0, 0,   0, 0, 1, 32'h1FFF_FFFF);
        add(0, 1, 0, 32'h0,        0, 0,   0, 0, 1, 32'h3FFF_FFFF);
        add(0, 1, 0, 32'h0,        0, 0,   0, 0, 1, 32'h7FFF_FFFF);
        add(0, 1, 0, 32'h0,        0, 0,   0, 0, 1, 32'hFFFF_FFFF);
        add(0, 1, 0, 32'h0,        0, 0,   1, 1, 1, 32'hFFFF_FFFE);
        // HOLD: req toggles, enable drops, value stays; ack+req returns to IDLE
        add(0, 1, 0, 32'h0,        1, 0,   1, 1, 1, 32'hFFFF_FFFC);
        add(0, 0, 0, 32'h0,        0, 0,   1, 1, 1, 32'hFFFF_FFFC);
        add(0, 0, 0, 32'h0,        1, 1,   0, 1, 0, 32'hFFFF_FFFC);
        add(0, 0, 0, 32'h0,        0, 0,   0, 1, 0, 32'hFFFF_FFFC);
        // seed 5 with req: accepted on the first DRAW cycle
        add(0, 1, 1, 32'h5,        1, 0,   0, 1, 1, 32'h0000_0005);
        add(0, 1, 0, 32'h0,        0, 0,   1, 5, 1, 32'h0000_000A);
        add(0, 1, 0, 32'h0,        0, 1,   0, 5, 0, 32'h0000_0015);
        // zero seed falls back to SEED
        add(0, 1, 1, 32'h0,        0, 0,   0, 5, 0, 32'h00FF_FFFF);
        // seed load mid-DRAW keeps the FSM; enable low stalls DRAW; reset aborts
        add(0, 1, 0, 32'h0,        1, 0,   0, 5, 1, 32'h01FF_FFFF);
        add(0, 1, 1, 32'h3,        0, 0,   0, 5, 1, 32'h0000_0003);
        add(0, 0, 0, 32'h0,        0, 0,   0, 5, 1, 32'h0000_0003);
        add(1, 0, 0, 32'h0,        0, 0,   0, 0, 0, 32'h00FF_FFFF);
        add(0, 0, 0, 32'h0,        0, 0,   0, 0, 0, 32'h00FF_FFFF);

        for (int i = 0; i < vecs.size(); i++) begin
            reset = vecs[i].rst; enable = vecs[i].en; seed_load = vecs[i].sl;
            seed_in = vecs[i].sin; req = vecs[i].rq; ack = vecs[i].ak;
            tick();
            n_vec++;
            if (valid !== vecs[i].e_valid || value !== vecs[i].e_value ||
                busy !== vecs[i].e_busy || state_out !== vecs[i].e_state) begin
                n_bad++;
                $display("FAIL vec%0d: valid/value/busy/state got %b/%0d/%b/%h expected %b/%0d/%b/%h",
                         i, valid, value, busy, state_out,
                         vecs[i].e_valid, vecs[i].e_value, vecs[i].e_busy, vecs[i].e_state);
            end
        end
        reset = 1'b0; enable = 1'b1; seed_load = 1'b0; req = 1'b0; ack = 1'b0;

        // NO_REPEAT: first draw 5, second draw sees only 5/A and falls back to 6
        tick();
        check("nr_reset_busy", {31'b0, nr_busy}, 32'h0);
        nr_reset = 1'b0; nr_seed_load = 1'b1; nr_seed_in = 32'h5; nr_req = 1'b1;
        tick();
        nr_seed_load = 1'b0; nr_req = 1'b0;
        tick();
        check("nr_first_valid", {31'b0, nr_valid}, 32'h1);
        check("nr_first_value", {28'b0, nr_value}, 32'h5);
        nr_ack = 1'b1;
        tick();
        nr_ack = 1'b0;
        check("nr_ack_valid", {31'b0, nr_valid}, 32'h0);
        nr_seed_load = 1'b1; nr_seed_in = 32'h5; nr_req = 1'b1;
        tick();
        check("nr_draw_state", nr_state_out, 32'h5);
        nr_seed_load = 1'b0; nr_req = 1'b0;
        lat = 0;
        while (!nr_valid && lat < 20) begin
            tick();
            lat++;
        end
        check("nr_latency", lat, 32'd8);
        check("nr_fallback_value", {28'b0, nr_value}, 32'h6);

        // Zero lockup recovery, independent of enable
        z_reset = 1'b0; z_seed_load = 1'b1; z_seed_in = 32'h8000_0000; z_enable = 1'b1;
        tick();
        check("zr_loaded", z_state_out, 32'h8000_0000);
        z_seed_load = 1'b0;
        tick();
        check("zr_zero", z_state_out, 32'h0);
        z_enable = 1'b0;
        tick();
        check("zr_recover", z_state_out, 32'h00FF_FFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
